uart_transceiver_cfg: RTL and testbench

Parametrised full-duplex UART with a configurable frame format and valid/ready handshakes on both directions. The data width, parity mode and stop-bit count are elaboration-time choices. The receiver oversamples the line and reports parity, framing and overrun errors. It is a drop-in successor for the fixed 8-bit transceiver and sits between the bus-side register logic and the pads.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tick_gen.sv | 37 +++
 rtl/uart_transceiver_cfg.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_transceiver_cfg.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transceiver.
// Parity is computed over a 9-bit container; narrower words are zero-extended.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned MAX_DATABITS = 9;

  // Zero padding does not change the XOR, so one width serves every frame format.
  function automatic logic calc_parity(input logic [MAX_DATABITS-1:0] data, input parity_e mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Clock divider emitting a one-cycle tick every c_div clocks, with synchronous clear.
// tick_next reports whether the following cycle will carry a tick.
module uart_tick_gen #(
  parameter int unsigned c_div = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned CW = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [CW-1:0] LAST = CW'(c_div - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    tick = (cnt == LAST);
    if (clr || tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
    tick_next = (cnt_next == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_transceiver_cfg.sv
// Full-duplex UART with elaboration-time frame format and valid/ready on both sides.
// The receiver oversamples a synchronized line and flags parity, framing and overrun.
module uart_transceiver_cfg
  import uart_pkg::*;
#(
  parameter int unsigned c_clkfreq    = 100_000_000,
  parameter int unsigned c_baudrate   = 1_000_000,
  parameter int unsigned c_oversample = 10,
  parameter int unsigned c_databits   = 8,
  parameter int unsigned c_parity     = 0,
  parameter int unsigned c_stopbit    = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  tx_valid_i,
  input  logic [c_databits-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  tx_o,
  output logic                  tx_active_o,
  output logic                  tx_done_tick_o,
  input  logic                  rx_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [c_databits-1:0] rx_data_o,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o
);

  localparam int unsigned c_tick_div = c_clkfreq / (c_baudrate * c_oversample);

  if (c_tick_div < 1 || c_oversample < 4 || (c_oversample % 2) != 0 ||
      c_databits < 5 || c_databits > 9 || c_parity > 2 ||
      c_stopbit < 1 || c_stopbit > 2) begin : g_bad_cfg
    $error("uart_transceiver_cfg: unsupported parameter set");
  end

  localparam int unsigned TCW = $clog2(c_oversample);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(c_oversample - 1);
  localparam logic [TCW-1:0] TICK_PRE  = TCW'(c_oversample - 2);
  localparam logic [TCW-1:0] TICK_HALF = TCW'(c_oversample / 2 - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(c_databits - 1);
  localparam logic           STOP_LAST = 1'(c_stopbit - 1);
  localparam parity_e PAR_MODE = (c_parity == 1) ? PAR_EVEN :
                                 (c_parity == 2) ? PAR_ODD  : PAR_NONE;

  // ---------------- transmitter ----------------
  tx_state_e                tx_state;
  logic [c_databits-1:0]    tx_shreg;
  logic                     tx_par;
  logic [TCW-1:0]           tx_tcnt;
  logic [3:0]               tx_bidx;
  logic                     tx_sidx;
  logic                     tx_tick;
  logic                     tx_tick_next;
  logic                     tx_accept;
  logic                     tx_bit_end;
  logic                     tx_done_next;
  logic [MAX_DATABITS-1:0]  tx_data_ext;

  uart_tick_gen #(.c_div(c_tick_div)) u_tx_tick (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .clr       (tx_accept),
    .tick      (tx_tick),
    .tick_next (tx_tick_next)
  );

  // The done pulse is registered, so it is raised one cycle ahead of the final tick.
  always_comb begin
    tx_accept    = tx_valid_i && tx_ready_o;
    tx_bit_end   = tx_tick && (tx_tcnt == TICK_LAST);
    tx_data_ext  = MAX_DATABITS'(tx_data_i);
    tx_done_next = (tx_state == TX_STOP) && (tx_sidx == STOP_LAST) && tx_tick_next &&
                   (tx_tick ? (tx_tcnt == TICK_PRE) : (tx_tcnt == TICK_LAST));
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      tx_state       <= TX_IDLE;
      tx_o           <= 1'b1;
      tx_ready_o     <= 1'b1;
      tx_active_o    <= 1'b0;
      tx_done_tick_o <= 1'b0;
      tx_shreg       <= '0;
      tx_par         <= 1'b0;
      tx_tcnt        <= '0;
      tx_bidx        <= '0;
      tx_sidx        <= 1'b0;
    end else begin
      tx_done_tick_o <= tx_done_next;
      if (tx_tick) begin
        tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_shreg    <= tx_data_i;
            tx_par      <= calc_parity(tx_data_ext, PAR_MODE);
            tx_tcnt     <= '0;
            tx_o        <= 1'b0;
            tx_ready_o  <= 1'b0;
            tx_active_o <= 1'b1;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_o     <= tx_shreg[0];
            tx_bidx  <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_shreg <= tx_shreg >> 1;
            if (tx_bidx == BIT_LAST) begin
              if (PAR_MODE != PAR_NONE) begin
                tx_o     <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_o     <= 1'b1;
                tx_sidx  <= 1'b0;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_bidx <= tx_bidx + 1'b1;
              tx_o    <= tx_shreg[1];
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_o     <= 1'b1;
            tx_sidx  <= 1'b0;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_sidx == STOP_LAST) begin
              tx_ready_o  <= 1'b1;
              tx_active_o <= 1'b0;
              tx_state    <= TX_IDLE;
            end else begin
              tx_sidx <= 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_e                rx_state;
  logic                     rx_s1;
  logic                     rx_s2;
  logic [c_databits-1:0]    rx_shreg;
  logic                     rx_par;
  logic [TCW-1:0]           rx_tcnt;
  logic [3:0]               rx_bidx;
  logic                     rx_tick;
  logic                     rx_tick_next_unused;
  logic                     rx_clr;
  logic                     rx_sample;
  logic                     rx_par_err;
  logic [MAX_DATABITS-1:0]  rx_data_ext;

  uart_tick_gen #(.c_div(c_tick_div)) u_rx_tick (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .clr       (rx_clr),
    .tick      (rx_tick),
    .tick_next (rx_tick_next_unused)
  );

  always_comb begin
    rx_clr      = (rx_state == RX_IDLE) && !rx_s2;
    rx_data_ext = MAX_DATABITS'(rx_shreg);
    rx_par_err  = (PAR_MODE != PAR_NONE) && (rx_par != calc_parity(rx_data_ext, PAR_MODE));
    case (rx_state)
      RX_START:                      rx_sample = rx_tick && (rx_tcnt == TICK_HALF);
      RX_DATA, RX_PARITY, RX_STOP:   rx_sample = rx_tick && (rx_tcnt == TICK_LAST);
      default:                       rx_sample = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
    end
  end

  // A frame ending in the same cycle the held word is taken is still an overrun:
  // delivery looks at the current rx_valid_o, not the post-handshake value.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_state        <= RX_IDLE;
      rx_valid_o      <= 1'b0;
      rx_data_o       <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_overrun_o    <= 1'b0;
      rx_shreg        <= '0;
      rx_par          <= 1'b0;
      rx_tcnt         <= '0;
      rx_bidx         <= '0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (rx_tick) begin
        rx_tcnt <= rx_sample ? '0 : rx_tcnt + 1'b1;
      end
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_tcnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_bidx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shreg <= {rx_s2, rx_shreg[c_databits-1:1]};
            if (rx_bidx == BIT_LAST) begin
              rx_state <= (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bidx <= rx_bidx + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_par   <= rx_s2;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            if (!rx_valid_o) begin
              rx_data_o       <= rx_shreg;
              rx_parity_err_o <= rx_par_err;
              rx_frame_err_o  <= !rx_s2;
              rx_valid_o      <= 1'b1;
            end else begin
              rx_overrun_o <= 1'b1;
            end
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s2) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Scoreboard bench: stimulus pushes expected RX words, per-DUT monitors pop and compare.
// Three instances cover 8N1, 8E1 loopback and 8O1 receive with a corrupted parity bit.
module tb_uart_transceiver_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic       m_tx_valid, m_tx_ready, m_tx, m_tx_active, m_tx_done;
  logic [7:0] m_tx_data, m_rx_data;
  logic       m_rx, m_rx_valid, m_rx_ready, m_perr, m_ferr, m_ovr;

  logic       l_tx_valid, l_tx_ready, l_tx, l_tx_active, l_tx_done;
  logic [7:0] l_tx_data, l_rx_data;
  logic       l_rx_valid, l_rx_ready, l_perr, l_ferr, l_ovr;

  logic       o_tx_valid, o_tx_ready, o_tx, o_tx_active, o_tx_done;
  logic [7:0] o_tx_data, o_rx_data;
  logic       o_rx, o_rx_valid, o_rx_ready, o_perr, o_ferr, o_ovr;

  uart_transceiver_cfg u_main (
    .clk_i(clk), .rstn_i(rstn),
    .tx_valid_i(m_tx_valid), .tx_data_i(m_tx_data), .tx_ready_o(m_tx_ready),
    .tx_o(m_tx), .tx_active_o(m_tx_active), .tx_done_tick_o(m_tx_done),
    .rx_i(m_rx), .rx_valid_o(m_rx_valid), .rx_ready_i(m_rx_ready), .rx_data_o(m_rx_data),
    .rx_parity_err_o(m_perr), .rx_frame_err_o(m_ferr), .rx_overrun_o(m_ovr)
  );

  uart_transceiver_cfg #(.c_parity(1)) u_loop (
    .clk_i(clk), .rstn_i(rstn),
    .tx_valid_i(l_tx_valid), .tx_data_i(l_tx_data), .tx_ready_o(l_tx_ready),
    .tx_o(l_tx), .tx_active_o(l_tx_active), .tx_done_tick_o(l_tx_done),
    .rx_i(l_tx), .rx_valid_o(l_rx_valid), .rx_ready_i(l_rx_ready), .rx_data_o(l_rx_data),
    .rx_parity_err_o(l_perr), .rx_frame_err_o(l_ferr), .rx_overrun_o(l_ovr)
  );

  uart_transceiver_cfg #(.c_parity(2)) u_odd (
    .clk_i(clk), .rstn_i(rstn),
    .tx_valid_i(o_tx_valid), .tx_data_i(o_tx_data), .tx_ready_o(o_tx_ready),
    .tx_o(o_tx), .tx_active_o(o_tx_active), .tx_done_tick_o(o_tx_done),
    .rx_i(o_rx), .rx_valid_o(o_rx_valid), .rx_ready_i(o_rx_ready), .rx_data_o(o_rx_data),
    .rx_parity_err_o(o_perr), .rx_frame_err_o(o_ferr), .rx_overrun_o(o_ovr)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t q_o[$];

  int vectors = 0;
  int miscompares = 0;
  int frames_m = 0, frames_l = 0, frames_o = 0;
  int ovr_m = 0, ovr_other = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void cmp_frame(input string tag, input int qsz, input exp_t e,
                                    input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_frame_expected"}, 32'(qsz != 0), 32'd1);
    if (qsz != 0) begin
      check({tag, "_data"}, 32'(d), 32'(e.data));
      check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
      check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int sz;
    if (rstn && m_rx_valid && m_rx_ready) begin
      frames_m++;
      sz = q_m.size();
      e = '{data: 8'h00, perr: 1'b0, ferr: 1'b0};
      if (sz != 0) e = q_m.pop_front();
      cmp_frame("main_rx", sz, e, m_rx_data, m_perr, m_ferr);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int sz;
    if (rstn && l_rx_valid && l_rx_ready) begin
      frames_l++;
      sz = q_l.size();
      e = '{data: 8'h00, perr: 1'b0, ferr: 1'b0};
      if (sz != 0) e = q_l.pop_front();
      cmp_frame("loop_rx", sz, e, l_rx_data, l_perr, l_ferr);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int sz;
    if (rstn && o_rx_valid && o_rx_ready) begin
      frames_o++;
      sz = q_o.size();
      e = '{data: 8'h00, perr: 1'b0, ferr: 1'b0};
      if (sz != 0) e = q_o.pop_front();
      cmp_frame("odd_rx", sz, e, o_rx_data, o_perr, o_ferr);
    end
  end

  always @(negedge clk) begin
    if (rstn && m_ovr) ovr_m++;
    if (rstn && (l_ovr || o_ovr)) ovr_other++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) m_rx = v;
    else            o_rx = v;
  endtask

  // bits[0] is driven first; each bit lasts one 100-clock bit period.
  task automatic drive_bits(input int which, input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, bits[i]);
      step(100);
    end
  endtask

  // line[i] is the expected tx_o level during bit period i of the frame.
  task automatic check_tx_frame(input string tag, input logic [7:0] data, input logic [9:0] line);
    int w;
    w = 0;
    while (!m_tx_ready && w < 2000) begin
      step(1);
      w++;
    end
    check({tag, "_ready_before"}, 32'(m_tx_ready), 32'd1);
    m_tx_data  = data;
    m_tx_valid = 1'b1;
    step(1);
    m_tx_valid = 1'b0;
    check({tag, "_active_c1"}, 32'(m_tx_active), 32'd1);
    check({tag, "_ready_c1"}, 32'(m_tx_ready), 32'd0);
    for (int c = 1; c <= 1001; c++) begin
      if (c <= 1000 && (c % 100 == 1 || c % 100 == 0))
        check($sformatf("%s_line_c%0d", tag, c), 32'(m_tx), 32'(line[(c - 1) / 100]));
      if (c == 999) check({tag, "_done_c999"}, 32'(m_tx_done), 32'd0);
      if (c == 1000) begin
        check({tag, "_done_c1000"}, 32'(m_tx_done), 32'd1);
        check({tag, "_ready_c1000"}, 32'(m_tx_ready), 32'd0);
      end
      if (c == 1001) begin
        check({tag, "_ready_c1001"}, 32'(m_tx_ready), 32'd1);
        check({tag, "_done_c1001"}, 32'(m_tx_done), 32'd0);
        check({tag, "_line_c1001"}, 32'(m_tx), 32'd1);
        check({tag, "_active_c1001"}, 32'(m_tx_active), 32'd0);
      end
      if (c < 1001) step(1);
    end
  endtask

  task automatic loop_accept(input string tag);
    int w;
    w = 0;
    while (!l_tx_ready && w < 3000) begin
      step(1);
      w++;
    end
    check({tag, "_ready_seen"}, 32'(l_tx_ready), 32'd1);
    step(1);
  endtask

  initial begin
    int f0;
    rstn = 1'b0;
    m_tx_valid = 1'b0; m_tx_data = 8'h00; m_rx = 1'b1; m_rx_ready = 1'b1;
    l_tx_valid = 1'b0; l_tx_data = 8'h00; l_rx_ready = 1'b1;
    o_tx_valid = 1'b0; o_tx_data = 8'h00; o_rx = 1'b1; o_rx_ready = 1'b1;
    step(3);
    check("rst_tx", 32'(m_tx), 32'd1);
    check("rst_tx_ready", 32'(m_tx_ready), 32'd1);
    check("rst_tx_active", 32'(m_tx_active), 32'd0);
    check("rst_tx_done", 32'(m_tx_done), 32'd0);
    check("rst_rx_valid", 32'(m_rx_valid), 32'd0);
    check("rst_rx_data", 32'(m_rx_data), 32'd0);
    check("rst_rx_perr", 32'(m_perr), 32'd0);
    check("rst_rx_ferr", 32'(m_ferr), 32'd0);
    check("rst_rx_ovr", 32'(m_ovr), 32'd0);
    rstn = 1'b1;
    step(2);

    // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
    check_tx_frame("tx_a5", 8'hA5, 10'b11_0100_1010);

    // Even-parity loopback, two words back to back
    q_l.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    q_l.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0});
    l_tx_data  = 8'h3C;
    l_tx_valid = 1'b1;
    loop_accept("loop_w0");
    l_tx_data = 8'hFF;
    loop_accept("loop_w1");
    l_tx_valid = 1'b0;
    step(1300);
    check("loop_frames", 32'(frames_l), 32'd2);

    // Odd parity receive: 0x31 with correct bit 0, then 0x96 with bit inverted to 0
    q_o.push_back('{data: 8'h31, perr: 1'b0, ferr: 1'b0});
    q_o.push_back('{data: 8'h96, perr: 1'b1, ferr: 1'b0});
    drive_bits(1, {1'b1, 1'b0, 8'h31, 1'b0}, 11);
    drive_bits(1, {1'b1, 1'b0, 8'h96, 1'b0}, 11);
    step(200);
    check("odd_frames", 32'(frames_o), 32'd2);

    // Break: line low for 2500 clocks
    q_m.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    f0 = frames_m;
    m_rx = 1'b0;
    step(2500);
    check("break_frames_low", 32'(frames_m - f0), 32'd1);
    m_rx = 1'b1;
    step(1500);
    check("break_frames_after", 32'(frames_m - f0), 32'd1);

    // 30-clock glitch
    f0 = frames_m;
    m_rx = 1'b0;
    step(30);
    m_rx = 1'b1;
    step(300);
    check("glitch_frames", 32'(frames_m - f0), 32'd0);

    // Overrun: two frames with rx_ready held low
    m_rx_ready = 1'b0;
    q_m.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
    drive_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
    step(20);
    check("ovr_valid_held", 32'(m_rx_valid), 32'd1);
    check("ovr_none_yet", 32'(ovr_m), 32'd0);
    drive_bits(0, {1'b1, 8'hC3, 1'b0}, 9);
    m_rx = 1'b1;
    step(40);
    check("ovr_before_mid_stop", 32'(ovr_m), 32'd0);
    step(60);
    check("ovr_after_mid_stop", 32'(ovr_m), 32'd1);
    check("ovr_data_kept", 32'(m_rx_data), 32'h5A);
    m_rx_ready = 1'b1;
    step(5);
    check("ovr_count_final", 32'(ovr_m), 32'd1);

    // Reset during data bit 3 of 0x55
    m_tx_data  = 8'h55;
    m_tx_valid = 1'b1;
    step(1);
    m_tx_valid = 1'b0;
    step(440);
    check("mid_rst_pre_active", 32'(m_tx_active), 32'd1);
    check("mid_rst_pre_line", 32'(m_tx), 32'd0);
    rstn = 1'b0;
    step(1);
    check("mid_rst_tx", 32'(m_tx), 32'd1);
    check("mid_rst_ready", 32'(m_tx_ready), 32'd1);
    check("mid_rst_active", 32'(m_tx_active), 32'd0);
    check("mid_rst_done", 32'(m_tx_done), 32'd0);
    rstn = 1'b1;
    step(5);

    // 0x81 after reset: 0,1,0,0,0,0,0,0,1,1
    check_tx_frame("tx_81", 8'h81, 10'b11_0000_0010);

    step(50);
    check("main_queue_empty", 32'(q_m.size()), 32'd0);
    check("loop_queue_empty", 32'(q_l.size()), 32'd0);
    check("odd_queue_empty", 32'(q_o.size()), 32'd0);
    check("other_overruns", 32'(ovr_other), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
